// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among
// N_REQ byte requesters. One frame is issued at a time. Frame completion is
// tracked through the transmitter's busy flag. A transmitter that never
// raises busy is reported on err.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_par_en,
  input  logic [N_REQ-1:0]         req_par_typ,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     Data_Valid,
  output logic [7:0]               P_DATA,
  output logic                     PAR_EN,
  output logic                     PAR_TYP,
  input  logic                     busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  // After reset the pointer sits on the last requester, so requester 0 is searched first.
  localparam logic [GW-1:0] LAST_ID = GW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RISE, WAIT_FALL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic          err_q, err_d;
  logic          dv_q, dv_d;
  logic [7:0]    p_data_q, p_data_d;
  logic          par_en_q, par_en_d;
  logic          par_typ_q, par_typ_d;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic          issue;

  // Per-requester bytes as an array so the winner's byte can be selected by index.
  logic [7:0] byte_arr [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign byte_arr[gi] = req_data[8*gi +: 8];
  end

  // Round-robin search: first pending request after the last grant, wrapping around.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  // Next-state and output logic; a grant can start from IDLE or straight out of WAIT_FALL.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    dv_d      = 1'b0;
    issue     = 1'b0;

    case (state_q)
      IDLE: begin
        // An externally busy transmitter blocks new frames.
        if (!busy && win_found) issue = 1'b1;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (busy) begin
          state_d = WAIT_FALL;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_FALL: begin
        if (!busy) begin
          done_d[grant_q] = 1'b1;
          // Chain the next frame in the completion cycle to avoid an idle gap.
          if (win_found) issue = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      ack_d[win_idx] = 1'b1;
      dv_d           = 1'b1;
      grant_d        = win_idx;
      p_data_d       = byte_arr[win_idx];
      par_en_d       = req_par_en[win_idx];
      par_typ_d      = req_par_typ[win_idx];
      state_d        = ISSUE;
    end
  end

  // State and output registers; reset abandons any frame in flight silently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= LAST_ID;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      dv_q      <= 1'b0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dv_q      <= dv_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign grant_id   = grant_q;
  assign Data_Valid = dv_q;
  assign P_DATA     = p_data_q;
  assign PAR_EN     = par_en_q;
  assign PAR_TYP    = par_typ_q;

endmodule
